// File: rtl/lsu_stage.sv
// Load/store unit stage: decodes memory ops from EX, runs one access at a time on a
// req/gnt/rvalid bus with a timeout, and registers results toward WB.
module lsu_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instr_i,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [4:0]        wbaddr_i,
    input  logic [31:0]       pc_next_i,
    output logic              stall_o,
    output logic              out_valid,
    output logic [XLEN-1:0]   data_o,
    output logic [4:0]        wbaddr_o,
    output logic [31:0]       pc_next_o,
    output logic [31:0]       instr_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            3'b100, 3'b101:         ok = !is_store;
            3'b110:                 ok = !is_store && (XLEN == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
        logic m;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a[1:0] != 2'b00);
            2'b11:   m = (a != 3'b000);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        logic [3:0] n;
        case (f3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [XLEN-1:0] lane);
        logic [XLEN-1:0] v;
        case (f3)
            3'b000:  v = XLEN'($signed(lane[7:0]));
            3'b001:  v = XLEN'($signed(lane[15:0]));
            3'b010:  v = XLEN'($signed(lane[31:0]));
            3'b100:  v = XLEN'(lane[7:0]);
            3'b101:  v = XLEN'(lane[15:0]);
            3'b110:  v = XLEN'(lane[31:0]);
            default: v = lane;
        endcase
        return v;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              ov_q, ov_d, err_q, err_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [4:0]        wb_q, wb_d;
    logic [31:0]       pc_q, pc_d, ins_q, ins_d;
    logic [2:0]        lat_f3_q, lat_f3_d;
    logic [OW-1:0]     lat_off_q, lat_off_d;
    logic [4:0]        lat_wb_q, lat_wb_d;
    logic [31:0]       lat_pc_q, lat_pc_d, lat_ins_q, lat_ins_d;
    logic              mwe_q, mwe_d;
    logic [XLEN-1:0]   maddr_q, maddr_d, mwdata_q, mwdata_d;
    logic [NB-1:0]     mbe_q, mbe_d;

    logic [2:0]        f3_s;
    logic              is_store_s, is_mem_s, bad_s, go_s, fin_s, fault_s;
    logic [OW-1:0]     off_s;
    logic [15:0]       mask_s;
    logic [XLEN-1:0]   lane_s;

    assign f3_s       = instr_i[14:12];
    assign off_s      = alu_i[OW-1:0];
    assign is_store_s = (instr_i[6:0] == OP_STORE);
    assign is_mem_s   = (instr_i[6:0] == OP_LOAD) || is_store_s;
    assign bad_s      = !f3_legal(is_store_s, f3_s) || misaligned(f3_s, alu_i[2:0]);
    // done_q marks the completion cycle: the held instruction on the inputs is the one just finished
    assign go_s       = in_valid && is_mem_s && !bad_s && !done_q;
    assign mask_s     = (16'd1 << size_bytes(f3_s)) - 16'd1;
    assign lane_s     = mem_rdata_i >> {lat_off_q, 3'b000};

    assign stall_o     = !reset && ((state_q != IDLE) || go_s);
    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mwe_q;
    assign mem_addr_o  = maddr_q;
    assign mem_be_o    = mbe_q;
    assign mem_wdata_o = mwdata_q;
    assign out_valid   = ov_q;
    assign err_o       = err_q;
    assign data_o      = data_q;
    assign wbaddr_o    = wb_q;
    assign pc_next_o   = pc_q;
    assign instr_o     = ins_q;

    // Next-state, acceptance latching and result formation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ov_d      = 1'b0;
        err_d     = err_q;
        data_d    = data_q;
        wb_d      = wb_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        lat_f3_d  = lat_f3_q;
        lat_off_d = lat_off_q;
        lat_wb_d  = lat_wb_q;
        lat_pc_d  = lat_pc_q;
        lat_ins_d = lat_ins_q;
        mwe_d     = mwe_q;
        maddr_d   = maddr_q;
        mbe_d     = mbe_q;
        mwdata_d  = mwdata_q;
        fin_s     = 1'b0;
        fault_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !done_q && !is_mem_s) begin
                    ov_d   = 1'b1;
                    err_d  = 1'b0;
                    data_d = alu_i;
                    wb_d   = wbaddr_i;
                    pc_d   = pc_next_i;
                    ins_d  = instr_i;
                end else if (in_valid && !done_q && bad_s) begin
                    ov_d   = 1'b1;
                    err_d  = 1'b1;
                    data_d = {XLEN{1'b0}};
                    wb_d   = 5'd0;
                    pc_d   = pc_next_i;
                    ins_d  = instr_i;
                end else if (go_s) begin
                    state_d   = REQ;
                    cnt_d     = 8'd0;
                    lat_f3_d  = f3_s;
                    lat_off_d = off_s;
                    lat_wb_d  = wbaddr_i;
                    lat_pc_d  = pc_next_i;
                    lat_ins_d = instr_i;
                    mwe_d     = is_store_s;
                    maddr_d   = {alu_i[XLEN-1:OW], {OW{1'b0}}};
                    mbe_d     = mask_s[NB-1:0] << off_s;
                    mwdata_d  = data_i << {off_s, 3'b000};
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    fin_s = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    fault_s = 1'b1;
                end else begin
                    state_d = mem_gnt_i ? WAIT : REQ;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    fin_s = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    fault_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin_s || fault_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ov_d    = 1'b1;
            err_d   = fault_s;
            data_d  = (fault_s || mwe_q) ? {XLEN{1'b0}} : load_extract(lat_f3_q, lane_s);
            wb_d    = (fault_s || mwe_q) ? 5'd0 : lat_wb_q;
            pc_d    = lat_pc_q;
            ins_d   = lat_ins_q;
        end else begin
            done_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            done_q    <= 1'b0;
            ov_q      <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= {XLEN{1'b0}};
            wb_q      <= 5'd0;
            pc_q      <= 32'd0;
            ins_q     <= 32'd0;
            lat_f3_q  <= 3'd0;
            lat_off_q <= {OW{1'b0}};
            lat_wb_q  <= 5'd0;
            lat_pc_q  <= 32'd0;
            lat_ins_q <= 32'd0;
            mwe_q     <= 1'b0;
            maddr_q   <= {XLEN{1'b0}};
            mbe_q     <= {NB{1'b0}};
            mwdata_q  <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            ov_q      <= ov_d;
            err_q     <= err_d;
            data_q    <= data_d;
            wb_q      <= wb_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            lat_f3_q  <= lat_f3_d;
            lat_off_q <= lat_off_d;
            lat_wb_q  <= lat_wb_d;
            lat_pc_q  <= lat_pc_d;
            lat_ins_q <= lat_ins_d;
            mwe_q     <= mwe_d;
            maddr_q   <= maddr_d;
            mbe_q     <= mbe_d;
            mwdata_q  <= mwdata_d;
        end
    end
endmodule
